// File: rtl/sha_2_pkg.sv
// sha_2_pkg: shared constants and the state type for the SHA-2 message
// builder. It holds the block width, the word width, the pad byte and the
// message_build state enum.
package sha_2_pkg;
   localparam int          BLOCK_W  = 512;
   localparam int          WORD_W   = 32;
   localparam logic [7:0]  PAD_BYTE = 8'h80;

   typedef enum logic [1:0] {
      ACCUM      = 2'd0,
      EMIT       = 2'd1,
      PAD_EMIT   = 2'd2,
      EXTRA_EMIT = 2'd3
   } state_e;
endpackage

// File: rtl/message_build_if.sv
// message_build_if: word-in / block-out handshake bundle for message_build.
//   data_in[31:0]     message word, first byte in [31:24]
//   data_in_nbytes    valid bytes in the word (left-justified), 0 = empty msg
//   data_in_last      final word of the message
//   data_in_valid/rdy input handshake
//   data_out[511:0]   padded block, word 0 in [511:480]
//   data_out_last     final block of the message
//   data_out_valid/rdy output handshake
// The master modport is the side that sources words and sinks blocks. The
// slave modport is the builder.
interface message_build_if;
   import sha_2_pkg::*;

   logic [WORD_W-1:0]  data_in;
   logic [2:0]         data_in_nbytes;
   logic               data_in_last;
   logic               data_in_valid;
   logic               data_in_ready;
   logic [BLOCK_W-1:0] data_out;
   logic               data_out_last;
   logic               data_out_valid;
   logic               data_out_ready;

   modport master (
      output data_in, data_in_nbytes, data_in_last, data_in_valid,
      input  data_in_ready,
      input  data_out, data_out_last, data_out_valid,
      output data_out_ready
   );

   modport slave (
      input  data_in, data_in_nbytes, data_in_last, data_in_valid,
      output data_in_ready,
      output data_out, data_out_last, data_out_valid,
      input  data_out_ready
   );
endinterface

// File: rtl/message_build.sv
// message_build: packs 32-bit message words into 512-bit SHA-2 blocks and
// appends the 0x80 pad byte, the zero fill and the 64-bit bit length.
//   clk       rising-edge clock
//   sync_rst  synchronous active-high reset. It takes effect even when en is low.
//   en        clock enable. When it is low, every register holds.
//   bus       message_build_if.slave (word input, block output)
// The block buffer is the output register. Bytes are stored in message order,
// so byte i of the block sits at blk_q[63-i].
module message_build
   import sha_2_pkg::*;
(
   input  logic           clk,
   input  logic           sync_rst,
   input  logic           en,
   message_build_if.slave bus
);

   state_e            state_q, state_d;
   logic [3:0]        w_q, w_d;
   logic [63:0]       cnt_q, cnt_d;
   logic [63:0][7:0]  blk_q, blk_d;
   logic              vld_q, vld_d;
   logic              last_q, last_d;
   logic              rdy_q, rdy_d;
   logic              xpad_q, xpad_d;   // extra block starts with the pad byte

   logic              in_xfer, out_xfer;
   logic [6:0]        base, pos;
   logic [63:0]       cnt_sum;
   logic [3:0][7:0]   din_b;
   logic [1:0]        kk;

   assign bus.data_out       = blk_q;
   assign bus.data_out_last  = last_q;
   assign bus.data_out_valid = vld_q;
   assign bus.data_in_ready  = rdy_q;

   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      cnt_d    = cnt_q;
      blk_d    = blk_q;
      vld_d    = vld_q;
      last_d   = last_q;
      rdy_d    = rdy_q;
      xpad_d   = xpad_q;
      kk       = 2'd0;
      in_xfer  = bus.data_in_valid && rdy_q && en;
      out_xfer = vld_q && bus.data_out_ready && en;
      din_b    = bus.data_in;
      base     = {1'b0, w_q, 2'b00};
      pos      = base + {4'b0, bus.data_in_nbytes};
      cnt_sum  = cnt_q + {61'b0, bus.data_in_nbytes};

      case (state_q)
         ACCUM: begin
            rdy_d = 1'b1;
            if (in_xfer) begin
               cnt_d = cnt_sum;
               // Word w gets the valid bytes. On the last word, the pad byte follows
               // and everything after it is zeroed. Unused input bytes never leak through.
               for (int i = 0; i < 64; i++) begin
                  if (7'(i) >= base) begin
                     if (7'(i) < pos) begin
                        kk = 2'(i - int'(base));
                        blk_d[63-i] = din_b[2'd3 - kk];
                     end else if (bus.data_in_last && 7'(i) == pos) begin
                        blk_d[63-i] = PAD_BYTE;
                     end else begin
                        blk_d[63-i] = 8'h00;
                     end
                  end
               end
               if (bus.data_in_last) begin
                  if (pos <= 7'd55) begin
                     blk_d[7:0] = cnt_sum << 3;
                     last_d     = 1'b1;
                  end else begin
                     last_d     = 1'b0;
                  end
                  xpad_d  = (pos == 7'd64);
                  state_d = PAD_EMIT;
                  vld_d   = 1'b1;
                  rdy_d   = 1'b0;
               end else if (w_q == 4'd15) begin
                  state_d = EMIT;
                  vld_d   = 1'b1;
                  last_d  = 1'b0;
                  rdy_d   = 1'b0;
               end else begin
                  w_d = w_q + 4'd1;
               end
            end
         end
         EMIT: begin
            if (out_xfer) begin
               state_d = ACCUM;
               w_d     = 4'd0;
               vld_d   = 1'b0;
               rdy_d   = 1'b1;
            end
         end
         PAD_EMIT: begin
            if (out_xfer) begin
               if (last_q) begin
                  state_d = ACCUM;
                  w_d     = 4'd0;
                  cnt_d   = 64'd0;
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
                  rdy_d   = 1'b1;
               end else begin
                  // The length did not fit, so the next block carries it.
                  blk_d      = '0;
                  blk_d[63]  = xpad_q ? PAD_BYTE : 8'h00;
                  blk_d[7:0] = cnt_q << 3;
                  last_d     = 1'b1;
                  state_d    = EXTRA_EMIT;
               end
            end
         end
         EXTRA_EMIT: begin
            if (out_xfer) begin
               state_d = ACCUM;
               w_d     = 4'd0;
               cnt_d   = 64'd0;
               vld_d   = 1'b0;
               last_d  = 1'b0;
               rdy_d   = 1'b1;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q <= ACCUM;
         w_q     <= 4'd0;
         cnt_q   <= 64'd0;
         blk_q   <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         rdy_q   <= 1'b0;
         xpad_q  <= 1'b0;
      end else if (en) begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         rdy_q   <= rdy_d;
         xpad_q  <= xpad_d;
      end
   end

endmodule

// File: doc/message_build.md
MESSAGE_BUILD -- requirements
Module: message_build

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed constants in sha_2_pkg.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 sync_rst  input  1  synchronous active-high reset.
REQ-005 en  input  1  clock enable; when low, every register holds its value.
REQ-006 data_in  input  32  message word; big-endian, first byte in [31:24].
REQ-007 data_in_nbytes  input  3  valid bytes in the word (1-4), left-justified; 0 is legal only with data_in_last (empty message).
REQ-008 data_in_last  input  1  marks the final word of the message.
REQ-009 data_in_valid / data_in_ready  input / output  1 each  input handshake; data_in_ready is registered.
REQ-010 data_out  output  512  padded block, word 0 in [511:480]; feeds hash_process data_in.
REQ-011 data_out_last  output  1  block is the final block of the message.
REQ-012 data_out_valid / data_out_ready  output / input  1 each  output handshake.

Function
REQ-013 An input transfer SHALL occur on a rising edge where data_in_valid && data_in_ready && en.
REQ-014 An output transfer SHALL occur on a rising edge where data_out_valid && data_out_ready && en.
REQ-015 The block SHALL implement four states: ACCUM, EMIT, PAD_EMIT, EXTRA_EMIT.
REQ-016 ACCUM SHALL store accepted words at word index w (0-15) and add nbytes to a 64-bit byte counter, which wraps modulo 2^64.
REQ-017 In ACCUM, a non-last 16th word SHALL cause transition to EMIT with data_out_last=0.
REQ-018 On the last word, byte 0x80 SHALL be written at byte position p = 4*w + nbytes, and all later bytes in the block SHALL be zero.
REQ-019 If p <= 55: words 14-15 SHALL hold the bit length (byte counter << 3, 64-bit big-endian); state goes to PAD_EMIT with data_out_last=1.
REQ-020 If 56 <= p <= 63: state SHALL go to PAD_EMIT with last=0, then EXTRA_EMIT with an all-zero block plus the length in words 14-15, last=1.
REQ-021 If p = 64 (full word at w=15): the first block SHALL carry no pad byte, last=0; the extra block SHALL have word 0 = 0x80000000 plus the length, last=1.
REQ-022 data_out_valid SHALL assert the cycle after the completing input transfer (latency 1); data_in_ready SHALL be 0 from that cycle until the final pending block transfers.
REQ-023 While data_out_valid=1 and data_out_ready=0, data_out and data_out_last SHALL hold stable.
REQ-024 After the output transfer of a last=0 non-extra block, the state SHALL return to ACCUM with w=0 and data_in_ready=1 the next cycle.
REQ-025 After the output transfer of a last=1 block, the byte counter and w SHALL clear, and the block SHALL be ready for a new message the next cycle.
REQ-026 Buffer bytes not written by the message or padding SHALL output as zero.

Reset
REQ-027 When sync_rst=1 at a rising edge, the block SHALL reset regardless of en: state=ACCUM, w=0, byte counter=0, buffer=0, data_out=0, data_out_valid=0, data_out_last=0, data_in_ready=0.
REQ-028 data_in_ready SHALL rise one cycle after sync_rst deasserts.
REQ-029 A reset mid-message or mid-output SHALL discard the partial message and any pending block with no output.

Structure
REQ-030 sha_2_pkg SHALL hold the block width (512), word width (32), pad byte 0x80, and the state enum typedef.
REQ-031 The block SHALL be a single module with no sub-modules; its output connects directly to hash_process.

Verification
REQ-032 Single-block message: "abc" as one word 0x61626300, nbytes=3, last -> one block: word0 0x61626380, words 1-14 zero, word15 0x00000018, last=1.
REQ-033 Empty message: nbytes=0, last -> word0 0x80000000, all other words zero, last=1.
REQ-034 Spill into an extra block: 56-byte message (14 full words) -> block1 with word14 0x80000000, word15 0, last=0; block2 all zero except word15 0x000001C0, last=1.
REQ-035 Exact multiple of 64 bytes: 64-byte message -> block1 equals the data, last=0; block2 word0 0x80000000, word15 0x00000200, last=1.
REQ-036 Backpressure and enable: hold data_out_ready low for 10 cycles, and toggle en -> data_out stable, data_in_ready=0, no extra blocks emitted.
REQ-037 Reset mid-message: assert sync_rst after 5 words, then send "abc" -> the output matches the block in REQ-032 exactly.
